// File: rtl/cpu_bus_pkg.sv
// Shared constants and types for the CPU-bus instruction loader.
package cpu_bus_pkg;
  localparam int unsigned INSTR_NUM_BIT = 8;
  localparam int unsigned ADDR_W        = INSTR_NUM_BIT + 1;
  localparam int unsigned HALF_W        = 32;

  localparam logic [ADDR_W-1:0] ADDR_LEN  = 9'h1FE;
  localparam logic [ADDR_W-1:0] ADDR_CTRL = 9'h1FF;

  localparam int unsigned CTRL_START   = 0;
  localparam int unsigned CTRL_IRQ_CLR = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_DRAIN
  } state_e;

  typedef logic [2*HALF_W-1:0] instr_t;
endpackage

// File: rtl/instr_store_2bank.sv
// Instruction store: low/high 32-bit banks, independent half writes, one registered read.
module instr_store_2bank
  import cpu_bus_pkg::*;
#(
  parameter int unsigned AW = INSTR_NUM_BIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_lo,
  input  logic              we_hi,
  input  logic [AW-1:0]     waddr,
  input  logic [HALF_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output instr_t            rdata
);
  localparam int unsigned DEPTH = 1 << AW;

  logic [HALF_W-1:0] bank_lo [DEPTH];
  logic [HALF_W-1:0] bank_hi [DEPTH];

  // Array contents are intentionally left unreset so a program survives a reset.
  always_ff @(posedge clk) begin
    if (we_lo) bank_lo[waddr] <= wdata;
    if (we_hi) bank_hi[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= {bank_hi[raddr], bank_lo[raddr]};
  end
endmodule

// File: rtl/instr_load_ctrl.sv
// Host-loaded instruction store that streams a program to the main controller on START
// and raises a sticky completion interrupt once the core has gone idle.
module instr_load_ctrl #(
  parameter int unsigned INSTR_NUM_BIT = cpu_bus_pkg::INSTR_NUM_BIT,
  parameter int unsigned INSTR_W       = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     CPU_instruction_valid,
  input  logic [INSTR_NUM_BIT:0]   CPU_instruction_addr,
  input  logic [31:0]              CPU_instruction_data,
  output logic                     CPU_instruction_irq,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [INSTR_W-1:0]       instr_data,
  output logic                     instr_last,
  input  logic                     core_idle,
  output logic                     busy
);
  import cpu_bus_pkg::*;

  state_e                   state;
  logic [INSTR_NUM_BIT-1:0] pc;
  logic [INSTR_NUM_BIT-1:0] len;
  logic                     start_q;
  logic                     irq_pend;
  logic                     drain_armed;
  instr_t                   rdata;

  logic host_idle_c;
  logic slot_wr_c;
  logic len_wr_c;
  logic ctrl_wr_c;
  logic start_c;
  logic irq_clr_c;

  // Host address decode; slot and LEN writes only land while idle.
  always_comb begin
    host_idle_c = (state == ST_IDLE);
    slot_wr_c   = CPU_instruction_valid && host_idle_c && (CPU_instruction_addr < ADDR_LEN);
    len_wr_c    = CPU_instruction_valid && host_idle_c && (CPU_instruction_addr == ADDR_LEN);
    ctrl_wr_c   = CPU_instruction_valid && (CPU_instruction_addr == ADDR_CTRL);
    start_c     = ctrl_wr_c && CPU_instruction_data[CTRL_START];
    irq_clr_c   = ctrl_wr_c && CPU_instruction_data[CTRL_IRQ_CLR];
  end

  instr_store_2bank #(
    .AW(INSTR_NUM_BIT)
  ) u_store (
    .clk   (clk),
    .rst   (rst),
    .we_lo (slot_wr_c && !CPU_instruction_addr[0]),
    .we_hi (slot_wr_c &&  CPU_instruction_addr[0]),
    .waddr (CPU_instruction_addr[INSTR_NUM_BIT:1]),
    .wdata (CPU_instruction_data),
    .re    (state == ST_FETCH),
    .raddr (pc),
    .rdata (rdata)
  );

  // The read register only loads in FETCH, so data holds through an ISSUE stall.
  assign instr_data = INSTR_W'(rdata);

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= ST_IDLE;
      pc                  <= '0;
      len                 <= '0;
      start_q             <= 1'b0;
      irq_pend            <= 1'b0;
      drain_armed         <= 1'b0;
      CPU_instruction_irq <= 1'b0;
      instr_valid         <= 1'b0;
      instr_last          <= 1'b0;
      busy                <= 1'b0;
    end else begin
      start_q  <= start_c && host_idle_c;
      irq_pend <= 1'b0;
      if (len_wr_c) len <= CPU_instruction_data[INSTR_NUM_BIT-1:0];
      // Later assignments win: a set in the same cycle overrides IRQ_CLR.
      if (irq_clr_c) CPU_instruction_irq <= 1'b0;
      if (irq_pend)  CPU_instruction_irq <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start_q) begin
            CPU_instruction_irq <= 1'b0;
            pc                  <= '0;
            if (len == '0) begin
              irq_pend <= 1'b1;
            end else begin
              state <= ST_FETCH;
              busy  <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          state       <= ST_ISSUE;
          instr_valid <= 1'b1;
          instr_last  <= (pc == len - INSTR_NUM_BIT'(1));
        end
        ST_ISSUE: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            instr_last  <= 1'b0;
            if (instr_last) begin
              state       <= ST_DRAIN;
              drain_armed <= 1'b0;
            end else begin
              pc    <= pc + INSTR_NUM_BIT'(1);
              state <= ST_FETCH;
            end
          end
        end
        ST_DRAIN: begin
          // First DRAIN cycle only arms; idle seen on entry may predate the last issue.
          if (!drain_armed) begin
            drain_armed <= 1'b1;
          end else if (core_idle) begin
            CPU_instruction_irq <= 1'b1;
            busy                <= 1'b0;
            drain_armed         <= 1'b0;
            state               <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_instr_load_ctrl.sv
// Bench for instr_load_ctrl: register-level vector table, directed corner runs and
// randomized programs checked against an array model of the instruction store.
module tb_instr_load_ctrl;
  import cpu_bus_pkg::*;

  localparam logic [63:0] S0 = 64'h11111111_22222222;
  localparam logic [63:0] S1 = 64'hAAAAAAAA_BBBBBBBB;

  logic        clk = 1'b0;
  logic        rst;
  logic        CPU_instruction_valid;
  logic [8:0]  CPU_instruction_addr;
  logic [31:0] CPU_instruction_data;
  logic        CPU_instruction_irq;
  logic        instr_valid;
  logic        instr_ready;
  logic [63:0] instr_data;
  logic        instr_last;
  logic        core_idle;
  logic        busy;

  always #5 clk = ~clk;

  instr_load_ctrl dut (
    .clk                   (clk),
    .rst                   (rst),
    .CPU_instruction_valid (CPU_instruction_valid),
    .CPU_instruction_addr  (CPU_instruction_addr),
    .CPU_instruction_data  (CPU_instruction_data),
    .CPU_instruction_irq   (CPU_instruction_irq),
    .instr_valid           (instr_valid),
    .instr_ready           (instr_ready),
    .instr_data            (instr_data),
    .instr_last            (instr_last),
    .core_idle             (core_idle),
    .busy                  (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_lo [256];
  logic [31:0] m_hi [256];
  int          m_len = 0;

  typedef struct {
    logic        wr;
    logic [8:0]  addr;
    logic [31:0] data;
    logic        irq;
    logic        busy;
    logic        vld;
  } vec_t;

  vec_t vt [17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [8:0] a, input logic [31:0] d);
    CPU_instruction_valid = 1'b1;
    CPU_instruction_addr  = a;
    CPU_instruction_data  = d;
    tick();
    CPU_instruction_valid = 1'b0;
  endtask

  task automatic load_slot(input int s, input logic [63:0] w);
    host_wr(9'(2 * s), w[31:0]);
    host_wr(9'(2 * s + 1), w[63:32]);
    m_lo[s] = w[31:0];
    m_hi[s] = w[63:32];
  endtask

  task automatic set_len(input int l);
    host_wr(ADDR_LEN, 32'(l));
    m_len = l;
  endtask

  task automatic start_prog();
    host_wr(ADDR_CTRL, 32'h1);
  endtask

  function automatic logic [63:0] slot(input int s);
    return {m_hi[s], m_lo[s]};
  endfunction

  function automatic vec_t mk(input logic wr, input logic [8:0] a, input logic [31:0] d,
                              input logic irq);
    mk = '{wr, a, d, irq, 1'b0, 1'b0};
  endfunction

  task automatic wait_valid(input string name);
    int n = 0;
    while (!instr_valid && n < 10) begin
      tick();
      n++;
    end
    check(name, 64'(instr_valid), 64'd1);
  endtask

  // Collect m_len handshakes against the model, then wait for the completion irq.
  task automatic collect(input int pct, input bit junk, input string tag);
    int idx   = 0;
    int cyc   = 0;
    bit seen  = 0;
    bit extra = 0;
    while (idx < m_len && cyc < m_len * 40 + 100) begin
      instr_ready = (int'($urandom_range(0, 99)) < pct);
      core_idle   = 1'($urandom_range(0, 1));
      if (junk && seen && $urandom_range(0, 3) == 0) begin
        CPU_instruction_valid = 1'b1;
        CPU_instruction_addr  = 9'($urandom_range(0, 'h1FE));
        CPU_instruction_data  = $urandom;
      end
      if (instr_valid && instr_ready) begin
        check($sformatf("%s_data%0d", tag, idx), instr_data, slot(idx));
        check($sformatf("%s_last%0d", tag, idx), 64'(instr_last), 64'(idx == m_len - 1));
        idx++;
      end
      if (instr_valid) seen = 1;
      tick();
      CPU_instruction_valid = 1'b0;
      cyc++;
    end
    check($sformatf("%s_count", tag), 64'(idx), 64'(m_len));
    instr_ready = 1'b0;
    cyc = 0;
    while (!CPU_instruction_irq && cyc < 200) begin
      core_idle = 1'($urandom_range(0, 1));
      if (instr_valid) extra = 1;
      tick();
      cyc++;
    end
    check($sformatf("%s_irq", tag), 64'(CPU_instruction_irq), 64'd1);
    check($sformatf("%s_busy_end", tag), 64'(busy), 64'd0);
    check($sformatf("%s_extra_valid", tag), 64'(extra), 64'd0);
    core_idle = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                   = 1'b1;
    CPU_instruction_valid = 1'b0;
    CPU_instruction_addr  = '0;
    CPU_instruction_data  = '0;
    instr_ready           = 1'b0;
    core_idle             = 1'b0;

    // Register-level table: LEN=0 runs, IRQ_CLR, START+IRQ_CLR, set-beats-clear.
    vt[0]  = mk(1'b1, ADDR_LEN,  32'h0, 1'b0);
    vt[1]  = mk(1'b1, ADDR_CTRL, 32'h1, 1'b0);
    vt[2]  = mk(1'b0, 9'h0,      32'h0, 1'b0);
    vt[3]  = mk(1'b0, 9'h0,      32'h0, 1'b1);
    vt[4]  = mk(1'b0, 9'h0,      32'h0, 1'b1);
    vt[5]  = mk(1'b1, ADDR_CTRL, 32'h2, 1'b0);
    vt[6]  = mk(1'b0, 9'h0,      32'h0, 1'b0);
    vt[7]  = mk(1'b1, ADDR_CTRL, 32'h1, 1'b0);
    vt[8]  = mk(1'b0, 9'h0,      32'h0, 1'b0);
    vt[9]  = mk(1'b0, 9'h0,      32'h0, 1'b1);
    vt[10] = mk(1'b1, ADDR_CTRL, 32'h3, 1'b0);
    vt[11] = mk(1'b0, 9'h0,      32'h0, 1'b0);
    vt[12] = mk(1'b0, 9'h0,      32'h0, 1'b1);
    vt[13] = mk(1'b1, ADDR_CTRL, 32'h1, 1'b1);
    vt[14] = mk(1'b0, 9'h0,      32'h0, 1'b0);
    vt[15] = mk(1'b1, ADDR_CTRL, 32'h2, 1'b1);
    vt[16] = mk(1'b0, 9'h0,      32'h0, 1'b1);

    tick();
    tick();
    rst = 1'b0;
    check("rst_irq",   64'(CPU_instruction_irq), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_last",  64'(instr_last), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_data",  instr_data, 64'd0);

    for (int i = 0; i < 17; i++) begin
      CPU_instruction_valid = vt[i].wr;
      CPU_instruction_addr  = vt[i].addr;
      CPU_instruction_data  = vt[i].data;
      tick();
      CPU_instruction_valid = 1'b0;
      check($sformatf("vec%0d_irq", i),   64'(CPU_instruction_irq), 64'(vt[i].irq));
      check($sformatf("vec%0d_busy", i),  64'(busy), 64'(vt[i].busy));
      check($sformatf("vec%0d_valid", i), 64'(instr_valid), 64'(vt[i].vld));
    end

    // Basic two-instruction program with exact issue timing.
    load_slot(0, S0);
    load_slot(1, S1);
    set_len(2);
    instr_ready = 1'b1;
    start_prog();
    check("a_valid_n0", 64'(instr_valid), 64'd0);
    tick();
    check("a_valid_n1", 64'(instr_valid), 64'd0);
    check("a_busy_n1",  64'(busy), 64'd1);
    tick();
    check("a_valid_n2", 64'(instr_valid), 64'd1);
    check("a_data0",    instr_data, S0);
    check("a_last0",    64'(instr_last), 64'd0);
    tick();
    check("a_valid_gap", 64'(instr_valid), 64'd0);
    tick();
    check("a_valid1", 64'(instr_valid), 64'd1);
    check("a_data1",  instr_data, S1);
    check("a_last1",  64'(instr_last), 64'd1);
    tick();
    check("a_valid_drain", 64'(instr_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("a_irq_wait%0d", i), 64'(CPU_instruction_irq), 64'd0);
      check($sformatf("a_busy_wait%0d", i), 64'(busy), 64'd1);
    end
    core_idle = 1'b1;
    tick();
    check("a_irq",      64'(CPU_instruction_irq), 64'd1);
    check("a_busy_end", 64'(busy), 64'd0);

    // Backpressure hold, then stale core_idle across DRAIN entry.
    instr_ready = 1'b0;
    start_prog();
    wait_valid("b_wait_valid");
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("b_hold_valid%0d", i), 64'(instr_valid), 64'd1);
      check($sformatf("b_hold_data%0d", i),  instr_data, S0);
      check($sformatf("b_hold_last%0d", i),  64'(instr_last), 64'd0);
    end
    instr_ready = 1'b1;
    tick();
    check("b_valid_gap", 64'(instr_valid), 64'd0);
    tick();
    check("b_data1", instr_data, S1);
    check("b_last1", 64'(instr_last), 64'd1);
    tick();
    instr_ready = 1'b0;
    check("b_irq_e0",  64'(CPU_instruction_irq), 64'd0);
    check("b_busy_e0", 64'(busy), 64'd1);
    tick();
    check("b_irq_e1",  64'(CPU_instruction_irq), 64'd0);
    check("b_busy_e1", 64'(busy), 64'd1);
    tick();
    check("b_irq_e2",  64'(CPU_instruction_irq), 64'd1);
    check("b_busy_e2", 64'(busy), 64'd0);
    core_idle = 1'b0;

    // Slot and LEN writes while busy are dropped.
    start_prog();
    wait_valid("c_wait_valid");
    host_wr(9'h002, 32'hDEADBEEF);
    host_wr(ADDR_LEN, 32'd7);
    collect(100, 1'b0, "c_run1");
    set_len(2);
    start_prog();
    collect(100, 1'b0, "c_run2");

    // Reset during ISSUE, then replay slot 0 with a fresh LEN.
    start_prog();
    wait_valid("d_wait_valid");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("d_valid", 64'(instr_valid), 64'd0);
    check("d_busy",  64'(busy), 64'd0);
    check("d_irq",   64'(CPU_instruction_irq), 64'd0);
    check("d_last",  64'(instr_last), 64'd0);
    check("d_data",  instr_data, 64'd0);
    set_len(1);
    start_prog();
    collect(100, 1'b0, "d_replay");

    // Randomized programs with random backpressure and dropped writes mid-run.
    for (int s = 0; s < 255; s++) load_slot(s, {$urandom, $urandom});
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++) begin
        int s = int'($urandom_range(0, 254));
        if ($urandom_range(0, 1) == 1) begin
          host_wr(9'(2 * s), $urandom);
          m_lo[s] = CPU_instruction_data;
        end else begin
          host_wr(9'(2 * s + 1), $urandom);
          m_hi[s] = CPU_instruction_data;
        end
      end
      set_len(int'($urandom_range(1, 20)));
      start_prog();
      collect(int'($urandom_range(30, 100)), 1'b1, $sformatf("rnd%0d", r));
    end
    set_len(255);
    start_prog();
    collect(100, 1'b1, "len255");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_load_ctrl.md
Name: instr_load_ctrl

Overview:
- Bus-side slave directly downstream of the CPU peripheral bus.
- Accepts 32-bit host writes and assembles 64-bit instructions into a 256-deep local instruction store.
- On a host start command it streams the program to the main controller over a valid/ready channel, waits for the core to go idle, then raises CPU_instruction_irq to signal completion.

Parameters:
- INSTR_NUM_BIT, 8: log2 of instruction store depth. The bus address is INSTR_NUM_BIT+1 bits wide.
- INSTR_W, 64: instruction width. Fixed at 2×32. Any other value is unsupported.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset. Same naming family as clk; no _n suffix because polarity is high.
- CPU_instruction_valid  in  1  host write strobe, one word per cycle.
- CPU_instruction_addr  in  INSTR_NUM_BIT+1  host word address.
- CPU_instruction_data  in  32  host write data.
- CPU_instruction_irq  out  1  completion interrupt, level and sticky.
- instr_valid  out  1  instruction available to the controller.
- instr_ready  in  1  controller accepts the instruction.
- instr_data  out  INSTR_W  instruction word.
- instr_last  out  1  marks the final instruction of the program.
- core_idle  in  1  controller/datapath has no work in flight.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Address map, decoded only when CPU_instruction_valid=1:
  - 0x000–0x1FD: instruction slot = addr[8:1], half = addr[0]. addr[0]=0 is bits[31:0], addr[0]=1 is bits[63:32]. Slots 0–254 are usable.
  - 0x1FE: LEN register. Program length = data[7:0], range 0–255. A value of 255 is clamped to 254+1, i.e. slots 0–254.
  - 0x1FF: CTRL. data[0]=START, data[1]=IRQ_CLR. Both are self-clearing; writes to CTRL are not stored.
- Halves are written independently; there is no pairing requirement. The store is two 32-bit banks with 1 write port and 1 synchronous read port each.
- Writes to instruction slots or LEN while busy=1 are dropped. IRQ_CLR is always honoured.
- FSM states: IDLE, FETCH, ISSUE, DRAIN.
  - IDLE: START=1 → clear irq and set pc=0.
    - If LEN=0: go to IDLE and set irq=1 next cycle.
    - Otherwise: go to FETCH.
  - FETCH: issue a read of slot pc. Go to ISSUE. Read data is registered into instr_data on this edge.
  - ISSUE: instr_valid=1, and instr_last=(pc==LEN-1). instr_data stays stable until the handshake (valid&ready).
    - On handshake, if last: go to DRAIN.
    - On handshake, if not last: pc++ and go to FETCH.
  - DRAIN: wait for core_idle=1. It is sampled from the cycle after entry, so a one-cycle-stale idle is ignored. Then irq=1 and go to IDLE.
- Latency: a START write sampled at edge N gives instr_valid=1 after edge N+2. Peak rate is one instruction per 2 cycles.
- START while busy is ignored.
- START together with IRQ_CLR in the same write: irq ends at 0 and the run starts.
- Irq set and IRQ_CLR in the same cycle: set wins.
- Reset values:
  - All outputs 0 (irq, instr_valid, instr_last, busy, instr_data).
  - State = IDLE, pc=0, LEN=0.
  - Store contents are not reset.
- Reset mid-run: the FSM returns to IDLE immediately and instr_valid drops the same cycle. The store keeps its data, so a new START replays the program once LEN is rewritten.
- Undefined addresses: none. The full 9-bit space is mapped.

Decomposition:
- Package cpu_bus_pkg holds:
  - INSTR_NUM_BIT
  - ADDR_LEN=9'h1FE and ADDR_CTRL=9'h1FF
  - CTRL bit indices
  - FSM state enum typedef
  - instruction word typedef logic[63:0]
- One sub-module: instr_store_2bank. Two 32×256 synchronous-read RAMs with per-half write enable.

Test Plan:
- Load slot0=0x11111111_22222222 and slot1=0xAAAAAAAA_BBBBBBBB, LEN=2, START, ready=1 → instr_data 0x1111111122222222 then 0xAAAAAAAABBBBBBBB. instr_last on the second only. irq=1 after core_idle=1.
- LEN=0, START → no instr_valid. irq=1 two edges after the write. busy stays 0.
- Hold instr_ready=0 for 5 cycles on instruction 0 → instr_valid and instr_data stay stable for all 5 cycles. No pc advance.
- While busy, write slot1 low=0xDEADBEEF and LEN=7 → both dropped. A later run with LEN=2 still issues the original slot1.
- Assert rst for 1 cycle during ISSUE → next cycle instr_valid=0, busy=0, irq=0. Rewrite LEN=1 and START → slot0 is reissued.
- After irq=1, write CTRL=0x2 → irq=0 next cycle. Write CTRL=0x3 while idle → irq=0 and the run starts.
